// File: rtl/shift_normalizer_if.sv
// Handshake and data bundle between a normalization requester and the shift normalizer.
interface shift_normalizer_if;
    logic        start;
    logic [15:0] data_in;
    logic        mode;
    logic        busy;
    logic        done;
    logic [15:0] data_out;
    logic [3:0]  shamt;
    logic        zero;

    modport master (
        output start, data_in, mode,
        input  busy, done, data_out, shamt, zero
    );

    modport slave (
        input  start, data_in, mode,
        output busy, done, data_out, shamt, zero
    );
endinterface

// File: rtl/shift_normalizer.sv
// Iterative left-shift normalizer: one bit per cycle until the operand is normalized
// (unsigned: msb set, signed: msb differs from bit 14) or the shift count reaches 15.
module shift_normalizer (
    input  logic               clk,
    input  logic               rst_n,
    shift_normalizer_if.slave  bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]  state_r;
    logic [15:0] work_r;
    logic        mode_r;
    logic [3:0]  count_r;
    logic        busy_r;
    logic        done_r;
    logic [15:0] data_out_r;
    logic [3:0]  shamt_r;
    logic        zero_r;

    function automatic logic is_normalized(input logic [15:0] word, input logic signed_mode);
        if (signed_mode) begin
            is_normalized = word[15] ^ word[14];
        end else begin
            is_normalized = word[15];
        end
    endfunction

    // Control FSM, working shift register and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            work_r     <= 16'h0000;
            mode_r     <= 1'b0;
            count_r    <= 4'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            data_out_r <= 16'h0000;
            shamt_r    <= 4'd0;
            zero_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        count_r <= 4'd0;
                        if (bus.data_in == 16'h0000) begin
                            // A zero operand can never normalize: report it immediately.
                            done_r     <= 1'b1;
                            data_out_r <= 16'h0000;
                            shamt_r    <= 4'd0;
                            zero_r     <= 1'b1;
                        end else begin
                            work_r  <= bus.data_in;
                            mode_r  <= bus.mode;
                            state_r <= SHIFT;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (is_normalized(work_r, mode_r) || (count_r == 4'd15)) begin
                        data_out_r <= work_r;
                        shamt_r    <= count_r;
                        zero_r     <= 1'b0;
                        done_r     <= 1'b1;
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                    end else begin
                        work_r  <= {work_r[14:0], 1'b0};
                        count_r <= count_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.data_out = data_out_r;
    assign bus.shamt    = shamt_r;
    assign bus.zero     = zero_r;

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed self-checking bench for shift_normalizer with hand-computed expectations.
module tb_shift_normalizer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    shift_normalizer_if bus ();

    shift_normalizer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done, then checks latency from the start-request cycle and the result.
    task automatic wait_and_check(input string tag, input int a, input logic seen_busy_in,
                                  input logic [15:0] e_out, input logic [3:0] e_sh,
                                  input logic e_zero, input int e_lat);
        int   n;
        logic seen_busy;
        n = 0;
        seen_busy = seen_busy_in;
        while (!bus.done && n < 40) begin
            seen_busy = seen_busy | bus.busy;
            step();
            n++;
        end
        check({tag, " done"}, {31'd0, bus.done}, 32'd1);
        check({tag, " latency"}, cyc - a, e_lat);
        check({tag, " data_out"}, {16'd0, bus.data_out}, {16'd0, e_out});
        check({tag, " shamt"}, {28'd0, bus.shamt}, {28'd0, e_sh});
        check({tag, " zero"}, {31'd0, bus.zero}, {31'd0, e_zero});
        check({tag, " busy in done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " busy seen"}, {31'd0, seen_busy}, {31'd0, ~e_zero});
    endtask

    task automatic run_op(input string tag, input logic [15:0] d, input logic m,
                          input logic [15:0] e_out, input logic [3:0] e_sh,
                          input logic e_zero, input int e_lat);
        int a;
        bus.data_in = d;
        bus.mode    = m;
        bus.start   = 1'b1;
        a = cyc;
        step();
        bus.start = 1'b0;
        wait_and_check(tag, a, 1'b0, e_out, e_sh, e_zero, e_lat);
        step();
        check({tag, " single pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, " hold"}, {16'd0, bus.data_out}, {16'd0, e_out});
    endtask

    initial begin
        int   a;
        int   n;
        logic seen_done;

        bus.start   = 1'b0;
        bus.data_in = 16'h0000;
        bus.mode    = 1'b0;
        rst_n       = 1'b0;
        step();
        step();
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset data_out", {16'd0, bus.data_out}, 32'd0);
        check("reset shamt", {28'd0, bus.shamt}, 32'd0);
        check("reset zero", {31'd0, bus.zero}, 32'd0);
        rst_n = 1'b1;
        step();

        run_op("u0010",  16'h0010, 1'b0, 16'h8000, 4'd11, 1'b0, 13);
        run_op("sFFF3",  16'hFFF3, 1'b1, 16'h9800, 4'd11, 1'b0, 13);
        run_op("s0001",  16'h0001, 1'b1, 16'h4000, 4'd14, 1'b0, 16);
        run_op("uzero",  16'h0000, 1'b0, 16'h0000, 4'd0,  1'b1, 1);
        run_op("szero",  16'h0000, 1'b1, 16'h0000, 4'd0,  1'b1, 1);
        run_op("u0001",  16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0, 17);
        run_op("u8000",  16'h8000, 1'b0, 16'h8000, 4'd0,  1'b0, 2);
        run_op("sFFFF",  16'hFFFF, 1'b1, 16'h8000, 4'd15, 1'b0, 17);
        run_op("s4000",  16'h4000, 1'b1, 16'h4000, 4'd0,  1'b0, 2);

        // Start pulsed while busy with a different operand must not disturb the result.
        bus.data_in = 16'h0100;
        bus.mode    = 1'b0;
        bus.start   = 1'b1;
        a = cyc;
        step();
        bus.start = 1'b0;
        step();
        bus.data_in = 16'h0003;
        bus.mode    = 1'b1;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        wait_and_check("busy-start", a, 1'b1, 16'h8000, 4'd7, 1'b0, 9);

        // Start held high through done: second operation is accepted in the done cycle.
        step();
        bus.data_in = 16'h0100;
        bus.mode    = 1'b0;
        bus.start   = 1'b1;
        a = cyc;
        step();
        wait_and_check("b2b first", a, 1'b1, 16'h8000, 4'd7, 1'b0, 9);
        bus.data_in = 16'h2000;
        a = cyc;
        step();
        bus.start = 1'b0;
        check("b2b second busy", {31'd0, bus.busy}, 32'd1);
        wait_and_check("b2b second", a, 1'b1, 16'h8000, 4'd2, 1'b0, 4);

        // Reset mid-SHIFT aborts the operation; start during reset is ignored.
        step();
        bus.data_in = 16'h0001;
        bus.mode    = 1'b0;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        rst_n       = 1'b0;
        bus.data_in = 16'h0000;
        bus.start   = 1'b1;
        step();
        rst_n     = 1'b1;
        bus.start = 1'b0;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort data_out", {16'd0, bus.data_out}, 32'd0);
        check("abort shamt", {28'd0, bus.shamt}, 32'd0);
        check("abort zero", {31'd0, bus.zero}, 32'd0);
        seen_done = 1'b0;
        for (n = 0; n < 20; n++) begin
            step();
            seen_done = seen_done | bus.done | bus.busy;
        end
        check("abort quiet", {31'd0, seen_done}, 32'd0);

        run_op("post-reset", 16'h0010, 1'b0, 16'h8000, 4'd11, 1'b0, 13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
